// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-road crossing scheduler: phase codes,
// lamp encodings, config register addresses and small decode helpers.
package semaforo_pkg;

    typedef enum logic [2:0] {
        A_VERDE   = 3'd0,
        A_AMARELO = 3'd1,
        VERM_1    = 3'd2,
        B_VERDE   = 3'd3,
        B_AMARELO = 3'd4,
        VERM_2    = 3'd5
    } estado_t;

    localparam logic [2:0] LUZ_VERDE    = 3'b001;
    localparam logic [2:0] LUZ_AMARELO  = 3'b010;
    localparam logic [2:0] LUZ_VERMELHO = 3'b100;

    localparam logic [1:0] CFG_VERDE     = 2'd0;
    localparam logic [1:0] CFG_AMARELO   = 2'd1;
    localparam logic [1:0] CFG_VERMELHO  = 2'd2;
    localparam logic [1:0] CFG_MIN_VERDE = 2'd3;

    // A configured duration of 0 behaves as 1, so the reload value never underflows.
    function automatic logic [7:0] dur_m1(logic [7:0] d);
        return (d == 8'd0) ? 8'd0 : d - 8'd1;
    endfunction

    function automatic logic [1:0] dur_addr(estado_t s);
        case (s)
            A_VERDE, B_VERDE:     return CFG_VERDE;
            A_AMARELO, B_AMARELO: return CFG_AMARELO;
            default:              return CFG_VERMELHO;
        endcase
    endfunction

    function automatic logic [2:0] lamp_a(estado_t s);
        case (s)
            A_VERDE:   return LUZ_VERDE;
            A_AMARELO: return LUZ_AMARELO;
            default:   return LUZ_VERMELHO;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(estado_t s);
        case (s)
            B_VERDE:   return LUZ_VERDE;
            B_AMARELO: return LUZ_AMARELO;
            default:   return LUZ_VERMELHO;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_scheduler_phase_timer.sv
// Per-phase timer: loadable down counter whose zero marks the phase end,
// plus a saturating cycles-in-phase counter (1 in the first cycle).
module phase_timer #(
    parameter logic [7:0] RST_CNT = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done,
    output logic [7:0] elapsed
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= RST_CNT;
            elapsed <= 8'd1;
        end else if (load) begin
            cnt     <= load_val;
            elapsed <= 8'd1;
        end else begin
            if (cnt != 8'd0)
                cnt <= cnt - 8'd1;
            if (elapsed != 8'd255)
                elapsed <= elapsed + 8'd1;
        end
    end

    assign done = (cnt == 8'd0);

endmodule

// File: rtl/semaforo_scheduler.sv
// Phase scheduler for a two-road crossing: green/yellow/all-red sequencing with
// configurable durations and pedestrian requests that can cut a green short.
module semaforo_scheduler
    import semaforo_pkg::*;
#(
    parameter logic [7:0] VERDE     = 8'd3,
    parameter logic [7:0] AMARELO   = 8'd1,
    parameter logic [7:0] VERMELHO  = 8'd2,
    parameter logic [7:0] MIN_VERDE = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_a,
    input  logic       bt_b,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] cfg_rdata,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic [2:0] phase,
    output logic [1:0] req
);

    localparam logic [7:0] RST_CNT = dur_m1(VERDE);

    estado_t    st, nxt;
    logic [7:0] cfg_mem [4];
    logic [7:0] elapsed;
    logic [7:0] min_eff;
    logic       done;
    logic       load;
    logic       exit_a, exit_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_mem[CFG_VERDE]     <= VERDE;
            cfg_mem[CFG_AMARELO]   <= AMARELO;
            cfg_mem[CFG_VERMELHO]  <= VERMELHO;
            cfg_mem[CFG_MIN_VERDE] <= MIN_VERDE;
        end else if (cfg_we) begin
            cfg_mem[cfg_addr] <= cfg_wdata;
        end
    end

    assign cfg_rdata = cfg_mem[cfg_addr];

    assign min_eff = (cfg_mem[CFG_MIN_VERDE] == 8'd0) ? 8'd1 : cfg_mem[CFG_MIN_VERDE];
    assign exit_a  = req[0] && (elapsed >= min_eff);
    assign exit_b  = req[1] && (elapsed >= min_eff);

    always_comb begin
        nxt = st;
        case (st)
            A_VERDE:   if (done || exit_a) nxt = A_AMARELO;
            A_AMARELO: if (done)           nxt = VERM_1;
            VERM_1:    if (done)           nxt = B_VERDE;
            B_VERDE:   if (done || exit_b) nxt = B_AMARELO;
            B_AMARELO: if (done)           nxt = VERM_2;
            VERM_2:    if (done)           nxt = A_VERDE;
            default:                       nxt = A_VERDE;
        endcase
    end

    // Every transition enters a different phase, so a state change is exactly a reload.
    assign load = (nxt != st);

    phase_timer #(
        .RST_CNT (RST_CNT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (dur_m1(cfg_mem[dur_addr(nxt)])),
        .done     (done),
        .elapsed  (elapsed)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= A_VERDE;
            A  <= LUZ_VERDE;
            B  <= LUZ_VERMELHO;
        end else begin
            st <= nxt;
            A  <= lamp_a(nxt);
            B  <= lamp_b(nxt);
        end
    end

    assign phase = st;

    // A button held on the edge that enters yellow keeps its request pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req <= 2'b00;
        end else begin
            req[0] <= bt_a | (req[0] & ~(load && nxt == A_AMARELO));
            req[1] <= bt_b | (req[1] & ~(load && nxt == B_AMARELO));
        end
    end

endmodule

// File: tb/tb_semaforo_scheduler.sv
// Bench for semaforo_scheduler: directed scenarios plus random buttons and config
// writes, compared each cycle against a duration/elapsed-based phase model.
module tb_semaforo_scheduler;
    import semaforo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bt_a = 1'b0, bt_b = 1'b0, cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic [7:0] cfg_rdata;
    logic [2:0] la, lb, phase;
    logic [1:0] req;

    int n_tests = 0;
    int n_fail  = 0;

    semaforo_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .bt_a      (bt_a),
        .bt_b      (bt_b),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .A         (la),
        .B         (lb),
        .phase     (phase),
        .req       (req)
    );

    always #5 clk = ~clk;

    // Reference model: phase ordinal 0..5 in sequence order, cycles spent in it,
    // duration fixed when the phase was entered, pending requests, config contents.
    int m_ph, m_t, m_dur;
    int m_cfg[4];
    bit m_req[2];
    logic [2:0] ph_code[6];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_t = 1; m_dur = 3;
        m_req[0] = 0; m_req[1] = 0;
        m_cfg[0] = 3; m_cfg[1] = 1; m_cfg[2] = 2; m_cfg[3] = 1;
    endtask

    task automatic model_step(input bit ba, input bit bb, input bit we, input int addr, input int wd);
        int  mn, nx, d;
        bit  fin;
        mn  = (m_cfg[3] == 0) ? 1 : m_cfg[3];
        fin = (m_t >= m_dur);
        if (m_ph == 0 && m_req[0] && m_t >= mn) fin = 1;
        if (m_ph == 3 && m_req[1] && m_t >= mn) fin = 1;
        nx = m_ph;
        if (fin) begin
            nx    = (m_ph + 1) % 6;
            d     = m_cfg[nx % 3];
            m_dur = (d == 0) ? 1 : d;
            m_t   = 1;
        end else begin
            m_t++;
        end
        m_req[0] = ba | (m_req[0] & !(fin && nx == 1));
        m_req[1] = bb | (m_req[1] & !(fin && nx == 4));
        if (we) m_cfg[addr] = wd;
        m_ph = nx;
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] ea, eb;
        ea = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        eb = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
        check({tag, ".A"}, {5'd0, la}, {5'd0, ea});
        check({tag, ".B"}, {5'd0, lb}, {5'd0, eb});
        check({tag, ".phase"}, {5'd0, phase}, {5'd0, ph_code[m_ph]});
        check({tag, ".req"}, {6'd0, req}, {6'd0, m_req[1], m_req[0]});
        check({tag, ".rdata"}, cfg_rdata, m_cfg[cfg_addr][7:0]);
    endtask

    // Called at a negedge; applies inputs, lets one edge pass, checks at the next negedge.
    task automatic step(input string tag, input bit ba, input bit bb,
                        input bit we, input int addr, input int wd);
        bt_a = ba; bt_b = bb; cfg_we = we;
        cfg_addr = addr[1:0]; cfg_wdata = wd[7:0];
        @(posedge clk);
        model_step(ba, bb, we, addr, wd);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, i % 4, 0);
    endtask

    // Reset is dropped between edges and must act without waiting for a clock.
    task automatic do_reset(input string tag);
        bt_a = 0; bt_b = 0; cfg_we = 0;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit reached;
        ph_code[0] = A_VERDE;  ph_code[1] = A_AMARELO; ph_code[2] = VERM_1;
        ph_code[3] = B_VERDE;  ph_code[4] = B_AMARELO; ph_code[5] = VERM_2;
        model_reset();

        @(negedge clk);
        do_reset("reset");
        idle("default_cycle", 26);

        do_reset("reset2");
        step("req_a_first", 1, 0, 0, 0, 0);
        check("req_a_set", {6'd0, req}, 8'd1);
        idle("req_a_exit", 12);

        do_reset("reset3");
        idle("cfg_pre", 1);
        step("cfg_green0", 0, 0, 1, 0, 0);
        idle("cfg_post", 14);

        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step("seek_b_yellow", 0, 1, 0, 0, 0);
            reached = (m_ph == 4);
        end
        check("seek_b_yellow_reached", {7'd0, reached}, 8'd1);
        do_reset("reset_mid_b_yellow");
        idle("after_reset", 8);

        idle("pre_both", 1);
        step("both_buttons", 1, 1, 0, 0, 0);
        idle("both_follow", 14);

        do_reset("reset4");
        step("min5", 0, 0, 1, 3, 5);
        for (int i = 0; i < 24; i++) step("hold_a", 1, 0, 0, 3, 0);

        do_reset("reset5");
        for (int i = 0; i < 3000; i++) begin
            bit ba, bb, we;
            ba = ($urandom_range(0, 5) == 0);
            bb = ($urandom_range(0, 5) == 0);
            we = ($urandom_range(0, 7) == 0);
            step("random", ba, bb, we, $urandom_range(0, 3), $urandom_range(0, 6));
            if ($urandom_range(0, 499) == 0) do_reset("random_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
